param_cpu: RTL and testbench

- Parametrised successor to the fixed 4-bit three-register datapath.
- Generalised in data width and program depth; adds a writable program store, a decoded opcode set, a run/halt handshake, a carry flag and a program counter with jump.
- Registers X, Y, Z, an ALU and a FETCH/EXECUTE controller, all under one clock domain.

---
 rtl/param_cpu_pkg.sv | 9 +
 rtl/param_cpu_if.sv | 17 +
 rtl/param_cpu_register.sv | 15 +
 rtl/param_cpu.sv | 104 ++++++++++
 tb/tb_param_cpu.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/param_cpu_pkg.sv
// param_cpu_pkg: shared opcode, register-control and state encodings for param_cpu
package cpu_pkg;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    OP_NOP, OP_LDX, OP_ADD, OP_SUB, OP_MOVZ, OP_CLR, OP_JMP, OP_HALT
  } op_e;
  typedef enum logic [1:0] {RC_HOLD = 2'b00, RC_LOAD = 2'b01, RC_CLEAR = 2'b10} reg_ctrl_e;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXECUTE, S_HALTED} state_e;
endpackage

// File: rtl/param_cpu_if.sv
// param_cpu_if: program-load, run/halt handshake and register observation bus
interface param_cpu_if import cpu_pkg::*; #(parameter int WIDTH = 4, parameter int PROG_DEPTH = 8);
  localparam int AW = $clog2(PROG_DEPTH);
  logic start;
  logic prog_we;
  logic [AW-1:0] prog_addr;
  logic [OP_W+WIDTH-1:0] prog_data;
  logic busy;
  logic halted;
  logic [AW-1:0] pc;
  logic [WIDTH-1:0] value_x, value_y, value_z;
  logic carry;
  modport master (output start, prog_we, prog_addr, prog_data,
                  input busy, halted, pc, value_x, value_y, value_z, carry);
  modport slave (input start, prog_we, prog_addr, prog_data,
                 output busy, halted, pc, value_x, value_y, value_z, carry);
endinterface

// File: rtl/param_cpu_register.sv
// cpu_register: WIDTH-bit register with 2-bit hold/load/clear control; code 11 holds
module cpu_register import cpu_pkg::*; #(parameter int WIDTH = 4) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       ctrl_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q, q_d;
  always_comb q_d = ctrl_i == RC_LOAD ? d_i : ctrl_i == RC_CLEAR ? '0 : q_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/param_cpu.sv
// param_cpu: X/Y/Z datapath with writable program store and FETCH/EXECUTE controller.
// Define CPU_SAT_EN for saturating ADD/SUB; otherwise arithmetic wraps.
module param_cpu import cpu_pkg::*; #(parameter int WIDTH = 4, parameter int PROG_DEPTH = 8) (
  input logic         clock,
  input logic         reset_n,
  param_cpu_if.slave  bus
);
  localparam int AW = $clog2(PROG_DEPTH);
  state_e state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [OP_W+WIDTH-1:0] ir_q, ir_d;
  logic carry_q, carry_d;
  logic [OP_W+WIDTH-1:0] mem_q [PROG_DEPTH];
  logic [WIDTH-1:0] x, y, z, y_d, add_y, sub_y;
  logic [WIDTH:0] sum, diff;
  reg_ctrl_e x_c, y_c, z_c;
  op_e op;
  logic busy;
  assign busy = state_q == S_FETCH || state_q == S_EXECUTE;
  assign op = op_e'(ir_q[OP_W+WIDTH-1 -: OP_W]);
  assign sum = {1'b0, y} + {1'b0, x};
  assign diff = {1'b0, y} - {1'b0, x};
`ifdef CPU_SAT_EN
  assign add_y = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  assign sub_y = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
  assign add_y = sum[WIDTH-1:0];
  assign sub_y = diff[WIDTH-1:0];
`endif
  // Program store is deliberately left out of reset so a loaded program survives it
  always_ff @(posedge clock)
    if (bus.prog_we && !busy) mem_q[bus.prog_addr] <= bus.prog_data;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      ir_q <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      carry_q <= carry_d;
    end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    carry_d = carry_q;
    x_c = RC_HOLD;
    y_c = RC_HOLD;
    z_c = RC_HOLD;
    y_d = add_y;
    case (state_q)
      S_IDLE, S_HALTED: if (bus.start) begin
        state_d = S_FETCH;
        pc_d = '0;
      end
      S_FETCH: begin
        ir_d = mem_q[pc_q];
        state_d = S_EXECUTE;
      end
      default: begin
        state_d = S_FETCH;
        pc_d = pc_q + AW'(1);
        case (op)
          OP_LDX: x_c = RC_LOAD;
          OP_ADD: begin
            y_c = RC_LOAD;
            carry_d = sum[WIDTH];
          end
          OP_SUB: begin
            y_c = RC_LOAD;
            y_d = sub_y;
            carry_d = diff[WIDTH];
          end
          OP_MOVZ: z_c = RC_LOAD;
          OP_CLR: begin
            x_c = RC_CLEAR;
            y_c = RC_CLEAR;
            z_c = RC_CLEAR;
            carry_d = 1'b0;
          end
          OP_JMP: pc_d = ir_q[AW-1:0];
          OP_HALT: begin
            state_d = S_HALTED;
            pc_d = pc_q;
          end
          default: ;
        endcase
      end
    endcase
  end
  cpu_register #(.WIDTH(WIDTH)) u_x (.clock(clock), .reset_n(reset_n), .ctrl_i(x_c), .d_i(ir_q[WIDTH-1:0]), .q_o(x));
  cpu_register #(.WIDTH(WIDTH)) u_y (.clock(clock), .reset_n(reset_n), .ctrl_i(y_c), .d_i(y_d), .q_o(y));
  cpu_register #(.WIDTH(WIDTH)) u_z (.clock(clock), .reset_n(reset_n), .ctrl_i(z_c), .d_i(y), .q_o(z));
  assign bus.busy = busy;
  assign bus.halted = state_q == S_HALTED;
  assign bus.pc = pc_q;
  assign bus.value_x = x;
  assign bus.value_y = y;
  assign bus.value_z = z;
  assign bus.carry = carry_q;
endmodule

// File: tb/tb_param_cpu.sv
// tb_param_cpu: directed program runs with a scoreboard of expected final register state
module tb_param_cpu;
  localparam int W = 4, D = 8;
  localparam logic [2:0] NOP = 3'd0, LDX = 3'd1, ADD = 3'd2, SUB = 3'd3, MOVZ = 3'd4, CLR = 3'd5, JMP = 3'd6, HALT = 3'd7;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  param_cpu_if #(.WIDTH(W), .PROG_DEPTH(D)) bus ();
  param_cpu #(.WIDTH(W), .PROG_DEPTH(D)) dut (.clock(clk), .reset_n(rst_n), .bus(bus));
  typedef struct {
    string tag;
    logic [W-1:0] x, y, z;
    logic c;
    logic [2:0] pc;
    int cyc;
  } exp_t;
  exp_t sb[$];
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(int a, logic [2:0] op, logic [W-1:0] imm);
    bus.prog_we = 1'b1;
    bus.prog_addr = 3'(a);
    bus.prog_data = {op, imm};
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask
  task automatic expect_run(string tag, logic [W-1:0] x, y, z, logic c, logic [2:0] pc, int cyc);
    sb.push_back('{tag, x, y, z, c, pc, cyc});
  endtask
  task automatic run(bit disturb);
    int cyc = 0;
    exp_t e;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.halted && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (disturb && cyc == 2) begin
        bus.start = 1'b1;
        bus.prog_we = 1'b1;
        bus.prog_addr = 3'd3;
        bus.prog_data = {NOP, 4'h0};
      end else begin
        bus.start = 1'b0;
        bus.prog_we = 1'b0;
      end
    end
    bus.start = 1'b0;
    bus.prog_we = 1'b0;
    chk("sb_nonempty", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_halted"}, bus.halted, 1);
      chk({e.tag, "_busy"}, bus.busy, 0);
      chk({e.tag, "_x"}, bus.value_x, e.x);
      chk({e.tag, "_y"}, bus.value_y, e.y);
      chk({e.tag, "_z"}, bus.value_z, e.z);
      chk({e.tag, "_carry"}, bus.carry, e.c);
      chk({e.tag, "_pc"}, bus.pc, e.pc);
      chk({e.tag, "_cycles"}, cyc, e.cyc);
    end
  endtask
  task automatic chk_reset(string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_halted"}, bus.halted, 0);
    chk({tag, "_pc"}, bus.pc, 0);
    chk({tag, "_x"}, bus.value_x, 0);
    chk({tag, "_y"}, bus.value_y, 0);
    chk({tag, "_z"}, bus.value_z, 0);
    chk({tag, "_carry"}, bus.carry, 0);
  endtask
  initial begin
    logic [2:0] pcs [6];
    pcs = '{3'd0, 3'd6, 3'd7, 3'd0, 3'd6, 3'd7};
    bus.start = 1'b0;
    bus.prog_we = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    // LDX 3; ADD; ADD; MOVZ; HALT
    wr(0, LDX, 4'd3); wr(1, ADD, 0); wr(2, ADD, 0); wr(3, MOVZ, 0); wr(4, HALT, 0);
    expect_run("basic", 4'd3, 4'd6, 4'd6, 1'b0, 3'd4, 10);
    run(0);
    // Wrap: CLR; LDX 15; ADD; ADD; HALT
    wr(0, CLR, 0); wr(1, LDX, 4'd15); wr(2, ADD, 0); wr(3, ADD, 0); wr(4, HALT, 0);
`ifdef CPU_SAT_EN
    expect_run("wrap", 4'd15, 4'd15, 4'd0, 1'b1, 3'd4, 10);
`else
    expect_run("wrap", 4'd15, 4'd14, 4'd0, 1'b1, 3'd4, 10);
`endif
    run(0);
    // Borrow with prog_we and start pulsed while busy; both must be ignored
    wr(0, CLR, 0); wr(1, LDX, 4'd5); wr(2, SUB, 0); wr(3, HALT, 0);
`ifdef CPU_SAT_EN
    expect_run("borrow", 4'd5, 4'd0, 4'd0, 1'b1, 3'd3, 8);
`else
    expect_run("borrow", 4'd5, 4'd11, 4'd0, 1'b1, 3'd3, 8);
`endif
    run(1);
    // Restart from HALTED keeps registers: ADD; HALT
    wr(0, ADD, 0); wr(1, HALT, 0);
`ifdef CPU_SAT_EN
    expect_run("restart", 4'd5, 4'd5, 4'd0, 1'b0, 3'd1, 4);
`else
    expect_run("restart", 4'd5, 4'd0, 4'd0, 1'b1, 3'd1, 4);
`endif
    run(0);
    // SUB without borrow, then abort mid-EXECUTE by reset
    wr(0, CLR, 0); wr(1, LDX, 4'd3); wr(2, ADD, 0); wr(3, LDX, 4'd1); wr(4, SUB, 0); wr(5, MOVZ, 0); wr(6, HALT, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_pc", bus.pc, 2);
    chk("mid_x", bus.value_x, 3);
    chk("mid_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_run("survive", 4'd1, 4'd2, 4'd2, 1'b0, 3'd6, 14);
    run(0);
    // JMP 14 (only low 3 bits used -> 6), HALT at 1 never reached
    wr(0, JMP, 4'd14); wr(1, HALT, 0); wr(6, NOP, 0); wr(7, NOP, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("jmp_pc%0d", k), bus.pc, pcs[k]);
      chk($sformatf("jmp_busy%0d", k), bus.busy, 1);
      repeat (2) @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr(0, NOP, 0);
    expect_run("nopfix", 4'd0, 4'd0, 4'd0, 1'b0, 3'd1, 4);
    run(0);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
